// File: rtl/line_buffer_ctrl_if.sv
// Row-in / window-out handshake bundle for the line buffer controller.
// Signal names are written from the controller's point of view (_i = into
// the controller, _o = out of it). The slave modport is the controller; the
// master modport is the upstream row source plus the downstream conv stage.
interface line_buffer_ctrl_if #(
   parameter int RW = 5
);
   logic          row_valid_i;
   logic          row_ready_o;
   logic          lb_wr_en_o;
   logic [1:0]    lb_wr_sel_o;
   logic          win_valid_o;
   logic          win_ready_i;
   logic [1:0]    win_top_sel_o;
   logic [RW-1:0] win_row_o;

   modport master (
      output row_valid_i, win_ready_i,
      input  row_ready_o, lb_wr_en_o, lb_wr_sel_o,
             win_valid_o, win_top_sel_o, win_row_o
   );

   modport slave (
      input  row_valid_i, win_ready_i,
      output row_ready_o, lb_wr_en_o, lb_wr_sel_o,
             win_valid_o, win_top_sel_o, win_row_o
   );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3-row line buffer feeding the KxK conv stage.
// Rows are written round-robin into three slots. Once three rows are
// resident, one window is offered per newly accepted row. After H-2 windows
// the frame ends with a one-cycle frame_done_o pulse.
// Optional build macro: LINE_BUFFER_CTRL_STALL_CNT_EN adds a saturating
// 16-bit count of cycles in which a window waited on the conv stage.
module line_buffer_ctrl #(
   parameter int H  = 24,  // rows per frame, 3..2^RW-1
   parameter int RW = 5    // row counter width, 2^RW > H
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   line_buffer_ctrl_if.slave   lb,
   output logic                frame_done_o,
   output logic                busy_o,
   output logic [15:0]         stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      LAST   = 2'd3
   } state_e;

   localparam logic [RW-1:0] LAST_ROW = RW'(H - 3);
   localparam logic [RW-1:0] ROWS_MAX = RW'(H);

   state_e        state_q, state_d;
   logic [1:0]    wr_ptr_q, wr_ptr_d;
   logic [RW-1:0] rows_in_q, rows_in_d;
   logic [RW-1:0] win_row_q, win_row_d;
   logic          win_valid_q, win_valid_d;

   logic          row_ready;
   logic          row_accept;
   logic          win_hs;

   // Row acceptance: always open while filling, closed while a window is pending.
   always_comb begin
      row_ready = 1'b0;
      case (state_q)
         FILL:    row_ready = 1'b1;
         STREAM:  row_ready = ~win_valid_q;
         default: row_ready = 1'b0;
      endcase
   end

   assign row_accept = lb.row_valid_i & row_ready;
   assign win_hs     = win_valid_q & lb.win_ready_i;

   // Next-state logic: pointer/counter advance on accept, window sequencing.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rows_in_d   = rows_in_q;
      win_row_d   = win_row_q;
      win_valid_d = win_valid_q;

      if (row_accept) begin
         wr_ptr_d  = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
         rows_in_d = (rows_in_q == ROWS_MAX) ? rows_in_q : rows_in_q + RW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = FILL;
               wr_ptr_d    = 2'd0;
               rows_in_d   = '0;
               win_row_d   = '0;
               win_valid_d = 1'b0;
            end
         end
         FILL: begin
            // Third row lands this edge: first window is complete next cycle.
            if (row_accept && rows_in_q == RW'(2)) begin
               state_d     = STREAM;
               win_valid_d = 1'b1;
            end
         end
         STREAM: begin
            if (win_hs) begin
               win_valid_d = 1'b0;
               if (win_row_q == LAST_ROW) state_d   = LAST;
               else                       win_row_d = win_row_q + RW'(1);
            end else if (row_accept) begin
               win_valid_d = 1'b1;
            end
         end
         LAST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= 2'd0;
         rows_in_q   <= '0;
         win_row_q   <= '0;
         win_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of its inputs, independent of statement order.
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rows_in_q   <= rows_in_d;
         win_row_q   <= win_row_d;
         win_valid_q <= win_valid_d;
      end
   end

`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Stall counter: cleared on frame start, saturating count of blocked windows.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && start_i) begin
         stall_cnt_d = '0;
      end else if (win_valid_q && !lb.win_ready_i && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 16'h0000;
`endif

   // The next slot to be overwritten always holds the oldest resident row.
   assign lb.row_ready_o   = row_ready;
   assign lb.lb_wr_en_o    = row_accept;
   assign lb.lb_wr_sel_o   = wr_ptr_q;
   assign lb.win_valid_o   = win_valid_q;
   assign lb.win_top_sel_o = wr_ptr_q;
   assign lb.win_row_o     = win_row_q;
   assign frame_done_o     = (state_q == LAST);
   assign busy_o           = (state_q != IDLE);

endmodule
